// File: rtl/time_pkg.sv
// Shared identifiers for the clock/alarm setting path: adjust field codes,
// repeat FSM states and default timing for a 50 MHz board clock.
package time_pkg;

  localparam int unsigned ADJ_W = 3;

  localparam logic [ADJ_W-1:0] ADJ_RUN     = 3'd0;
  localparam logic [ADJ_W-1:0] ADJ_SEC     = 3'd1;
  localparam logic [ADJ_W-1:0] ADJ_MIN     = 3'd2;
  localparam logic [ADJ_W-1:0] ADJ_HOUR    = 3'd3;
  localparam logic [ADJ_W-1:0] ADJ_AL_MIN  = 3'd4;
  localparam logic [ADJ_W-1:0] ADJ_AL_HOUR = 3'd5;

  localparam int unsigned DEF_DB_CYC      = 1_000_000;
  localparam int unsigned DEF_REP_DLY     = 25_000_000;
  localparam int unsigned DEF_REP_PER     = 10_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = 500_000_000;
  localparam int unsigned DEF_NUM_FIELDS  = 5;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_WAIT   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  // Mode key walks run -> 1 -> ... -> num_fields -> run.
  function automatic logic [ADJ_W-1:0] next_adjust(input logic [ADJ_W-1:0] cur,
                                                   input int unsigned num_fields);
    if (cur >= ADJ_W'(num_fields)) return ADJ_RUN;
    return cur + ADJ_W'(1);
  endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Button inputs and adjust/strobe outputs of the time-setting front-end.
interface time_adjust_ctrl_if;
  import time_pkg::*;

  logic             key_mode_n;
  logic             key_up_n;
  logic             key_down_n;
  logic [ADJ_W-1:0] adjust;
  logic             key2;
  logic             key3;
  logic             run;

  modport master (output key_mode_n, key_up_n, key_down_n,
                  input  adjust, key2, key3, run);
  modport slave  (input  key_mode_n, key_up_n, key_down_n,
                  output adjust, key2, key3, run);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability debouncer for one active-low button;
// pressed is the debounced level, press a one-cycle pulse on its rising edge.
module key_debounce
  import time_pkg::*;
#(
  parameter int unsigned DB_CYC = DEF_DB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_CYC + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_c;

  assign level_c = ~sync_q[1];

  // Any cycle agreeing with the current level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (level_c == pressed) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_W'(DB_CYC - 1)) begin
        cnt_q   <= '0;
        pressed <= level_c;
        press   <= level_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Clock/alarm setting front-end: mode key selects the field, up/down keys
// produce key2/key3 strobes with auto-repeat, idle fields time out to run.
module time_adjust_ctrl
  import time_pkg::*;
#(
  parameter int unsigned DB_CYC      = DEF_DB_CYC,
  parameter int unsigned REP_DLY     = DEF_REP_DLY,
  parameter int unsigned REP_PER     = DEF_REP_PER,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned NUM_FIELDS  = DEF_NUM_FIELDS
) (
  input  logic clk,
  input  logic rst,
  time_adjust_ctrl_if.slave bus
);

  localparam int unsigned TMR_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned K_MODE  = 0;

  logic [2:0] raw_n, prs, evt;

  assign raw_n = {bus.key_down_n, bus.key_up_n, bus.key_mode_n};

  for (genvar g = 0; g < 3; g++) begin : g_db
    key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk     (clk),
      .rst     (rst),
      .key_n   (raw_n[g]),
      .pressed (prs[g]),
      .press   (evt[g])
    );
  end

  logic [ADJ_W-1:0] adjust_q, adjust_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             lock_q, lock_d;
  rep_state_t       st_q [2];
  rep_state_t       st_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];
  logic [1:0]       fire_c;
  logic             key2_q, key3_q;
  logic             tmo_hit_c, force_idle_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      adjust_q <= ADJ_RUN;
      tmo_q    <= '0;
      lock_q   <= 1'b0;
      key2_q   <= 1'b0;
      key3_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= REP_IDLE;
        tmr_q[i] <= '0;
      end
    end else begin
      adjust_q <= adjust_d;
      tmo_q    <= tmo_d;
      lock_q   <= lock_d;
      key2_q   <= fire_c[0];
      key3_q   <= fire_c[1] & ~fire_c[0];
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  // Index 0 is the up key (prs[1]), index 1 the down key (prs[2]).
  always_comb begin
    adjust_d = adjust_q;
    tmo_d    = tmo_q;
    fire_c   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
    end

    // Holding both keys locks out strobes until both are released again.
    lock_d       = (prs[1] & prs[2]) | (lock_q & (prs[1] | prs[2]));
    tmo_hit_c    = (adjust_q != ADJ_RUN) && (tmo_q >= TMO_W'(TIMEOUT_CYC - 1));
    force_idle_c = (adjust_q == ADJ_RUN) || lock_d || lock_q || prs[K_MODE] ||
                   evt[K_MODE] || tmo_hit_c;

    for (int i = 0; i < 2; i++) begin
      if (force_idle_c || !prs[i+1]) begin
        st_d[i]  = REP_IDLE;
        tmr_d[i] = '0;
      end else begin
        unique case (st_q[i])
          REP_IDLE: if (evt[i+1]) begin
            fire_c[i] = 1'b1;
            st_d[i]   = REP_WAIT;
            tmr_d[i]  = TMR_W'(1);  // the press cycle counts toward the delay
          end
          REP_WAIT: if (tmr_q[i] >= TMR_W'(REP_DLY - 1)) begin
            fire_c[i] = 1'b1;
            st_d[i]   = REP_REPEAT;
            tmr_d[i]  = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
          REP_REPEAT: if (tmr_q[i] >= TMR_W'(REP_PER - 1)) begin
            fire_c[i] = 1'b1;
            tmr_d[i]  = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
          default: begin
            st_d[i]  = REP_IDLE;
            tmr_d[i] = '0;
          end
        endcase
      end
    end

    if (evt[K_MODE])    adjust_d = next_adjust(adjust_q, NUM_FIELDS);
    else if (tmo_hit_c) adjust_d = ADJ_RUN;

    // Idle timer restarts on any user activity and saturates at the limit.
    if ((adjust_q == ADJ_RUN) || (|evt) || (|fire_c)) tmo_d = '0;
    else if (!tmo_hit_c)                               tmo_d = tmo_q + TMO_W'(1);
  end

  assign bus.adjust = adjust_q;
  assign bus.key2   = key2_q;
  assign bus.key3   = key3_q;
  assign bus.run    = (adjust_q == ADJ_RUN);

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Scoreboard bench for time_adjust_ctrl: predicted adjust/key2/key3 events are
// queued at stimulus time and matched, cycle-exact, against what the DUT emits.
module tb_time_adjust_ctrl;
  import time_pkg::*;

  localparam int unsigned DB = 4, RD = 20, RP = 8, TO = 200, NF = 5;
  localparam int LAT = 7;  // raw edge -> first registered output
  localparam int EV_ADJ = 1, EV_K2 = 2, EV_K3 = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  time_adjust_ctrl_if bus();

  time_adjust_ctrl #(
    .DB_CYC(DB), .REP_DLY(RD), .REP_PER(RP), .TIMEOUT_CYC(TO), .NUM_FIELDS(NF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t        sb_q[$];
  int         n_tests = 0, n_fail = 0;
  int         tb_adj = 0, last_adj_cyc = 0;
  int         k2_cnt = 0, k3_cnt = 0;
  logic [2:0] prev_adj = 3'd0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int v);
    ev_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_event", kind, 0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_cycle", cyc, e.cyc);
      chk("sb_value", v, e.val);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.key2 === 1'b1) begin k2_cnt++; sb_pop(EV_K2, 1); end
      if (bus.key3 === 1'b1) begin k3_cnt++; sb_pop(EV_K3, 1); end
      if (bus.adjust !== prev_adj) begin
        prev_adj = bus.adjust;
        sb_pop(EV_ADJ, int'(bus.adjust));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_adjust"}, int'(bus.adjust), tb_adj);
    chk({tag, "_run"}, int'(bus.run), (tb_adj == 0) ? 1 : 0);
    chk({tag, "_key2"}, int'(bus.key2), 0);
    chk({tag, "_key3"}, int'(bus.key3), 0);
  endtask

  task automatic mode_press();
    int n;
    n = cyc;
    bus.key_mode_n = 1'b0;
    tb_adj = (tb_adj >= int'(NF)) ? 0 : tb_adj + 1;
    last_adj_cyc = n + LAT;
    sb_push(EV_ADJ, last_adj_cyc, tb_adj);
    tick(8);
    bus.key_mode_n = 1'b1;
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, u, k2_base, k3_base;
    bus.key_mode_n = 1'b1;
    bus.key_up_n   = 1'b1;
    bus.key_down_n = 1'b1;
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    fork monitor(); join_none
    tick(2);

    // Up key in run mode is ignored.
    k2_base = k2_cnt;
    bus.key_up_n = 1'b0; tick(50);
    bus.key_up_n = 1'b1; tick(10);
    chk("run_mode_no_key2", k2_cnt - k2_base, 0);
    check_quiet("run_idle");

    // Glitchy mode key gives exactly one advance, then five clean presses.
    for (int g = 0; g < 3; g++) begin
      bus.key_mode_n = 1'b0; tick(3);
      bus.key_mode_n = 1'b1; tick(2);
    end
    n = cyc;
    bus.key_mode_n = 1'b0;
    tb_adj = 1;
    sb_push(EV_ADJ, n + LAT, 1);
    tick(10);
    bus.key_mode_n = 1'b1; tick(10);
    check_quiet("glitch_one_step");
    for (int i = 0; i < 5; i++) mode_press();
    check_quiet("mode_wrap");

    // Field 2, up held: first strobe, delayed repeat, then periodic repeats.
    mode_press(); mode_press();
    k3_base = k3_cnt;
    n = cyc;
    bus.key_up_n = 1'b0;
    sb_push(EV_K2, n + 7, 1);
    for (int r = 0; r < 5; r++) sb_push(EV_K2, n + 26 + r * int'(RP), 1);
    wait_until(n + 57);
    bus.key_up_n = 1'b1;
    wait_until(n + 75);
    chk("up_hold_no_key3", k3_cnt - k3_base, 0);
    check_quiet("up_hold_done");

    // Field 1, down held then up joins: strobes stop until a clean re-press.
    for (int i = 0; i < 5; i++) mode_press();
    n = cyc;
    bus.key_down_n = 1'b0;
    sb_push(EV_K3, n + 7, 1);
    sb_push(EV_K3, n + 26, 1);
    sb_push(EV_K3, n + 34, 1);
    wait_until(n + 30); bus.key_up_n = 1'b0;
    wait_until(n + 45); bus.key_up_n = 1'b1;
    wait_until(n + 70); bus.key_down_n = 1'b1;
    wait_until(n + 80);
    check_quiet("both_locked");
    n = cyc;
    bus.key_down_n = 1'b0;
    sb_push(EV_K3, n + 7, 1);
    tick(10);
    bus.key_down_n = 1'b1;
    tick(10);

    // Field 3, mode press during repeat: advance to 4, repeats cease.
    mode_press(); mode_press();
    k2_base = k2_cnt;
    n = cyc;
    bus.key_up_n = 1'b0;
    sb_push(EV_K2, n + 7, 1);
    sb_push(EV_K2, n + 26, 1);
    sb_push(EV_K2, n + 34, 1);
    sb_push(EV_K2, n + 42, 1);
    wait_until(n + 36);
    bus.key_mode_n = 1'b0;
    tb_adj = 4;
    sb_push(EV_ADJ, n + 43, 4);
    wait_until(n + 44); bus.key_mode_n = 1'b1;
    wait_until(n + 80); bus.key_up_n = 1'b1;
    wait_until(n + 96);
    chk("mode_stops_repeat_cnt", k2_cnt - k2_base, 4);
    check_quiet("mode_during_repeat");

    // Field 2 idle: return to run exactly TO cycles after entering the field.
    for (int i = 0; i < 4; i++) mode_press();
    sb_push(EV_ADJ, last_adj_cyc + int'(TO), 0);
    wait_until(last_adj_cyc + int'(TO) + 5);
    tb_adj = 0;
    check_quiet("timeout_plain");

    // A press 150 cycles in restarts the idle count from that press.
    mode_press(); mode_press();
    wait_until(last_adj_cyc + 144);
    u = cyc;
    bus.key_up_n = 1'b0;
    sb_push(EV_K2, u + 7, 1);
    sb_push(EV_ADJ, u + 7 + int'(TO), 0);
    tick(8);
    bus.key_up_n = 1'b1;
    wait_until(u + 200);
    check_quiet("timeout_restarted");
    wait_until(u + 215);
    tb_adj = 0;
    check_quiet("timeout_after_press");

    // Reset in the middle of auto-repeat.
    mode_press();
    n = cyc;
    bus.key_up_n = 1'b0;
    sb_push(EV_K2, n + 7, 1);
    sb_push(EV_K2, n + 26, 1);
    sb_push(EV_K2, n + 34, 1);
    wait_until(n + 38);
    rst = 1'b1;
    sb_push(EV_ADJ, n + 39, 0);
    tick(1);
    tb_adj = 0;
    check_quiet("reset_mid_repeat");
    m = cyc;
    bus.key_up_n = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_until(m + 25);
    check_quiet("after_reset");

    chk("sb_pending_events", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
